// File: rtl/bus_if.sv
// Pipeline-side memory access unit: SPM hits are served combinationally (zero wait), other regions go through a bus master handshake.
// Bus accesses stall the stage via busy until bus_rdy_; stall holds the completed read data, flush only masks new requests.
module bus_if #(
    parameter int                SEL_W   = 3,
    parameter logic [SEL_W-1:0]  SPM_SEL = 3'b001,
    parameter int                SPM_AW  = 12
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               stall,
    input  logic               flush,
    output logic               busy,
    input  logic [29:0]        addr,
    input  logic               as_,
    input  logic               rw,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    input  logic [31:0]        spm_rd_data,
    output logic [SPM_AW-1:0]  spm_addr,
    output logic               spm_as_,
    output logic               spm_rw,
    output logic [31:0]        spm_wr_data,
    input  logic [31:0]        bus_rd_data,
    input  logic               bus_rdy_,
    input  logic               bus_grnt_,
    output logic               bus_req_,
    output logic [29:0]        bus_addr,
    output logic               bus_as_,
    output logic               bus_rw,
    output logic [31:0]        bus_wr_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_rd_buf;

    logic w_spm_region;
    logic w_new_req;
    logic w_spm_hit;
    logic w_bus_hit;

    assign w_spm_region = (addr[29:30-SEL_W] == SPM_SEL);
    assign w_new_req    = (r_state == IDLE) && !as_ && !flush;
    assign w_spm_hit    = w_new_req && w_spm_region;
    assign w_bus_hit    = w_new_req && !w_spm_region;

    assign spm_addr    = addr[SPM_AW-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = !w_spm_hit;

    always_comb begin
        busy    = 1'b0;
        rd_data = r_rd_buf;
        case (r_state)
            IDLE: begin
                busy = w_bus_hit;
                if (w_spm_hit) begin
                    rd_data = spm_rd_data;
                end
            end
            REQ: begin
                busy = 1'b1;
            end
            ACCESS: begin
                // Ready data bypasses rd_buf so the stage sees it in the completing cycle.
                busy = bus_rdy_;
                if (!bus_rdy_) begin
                    rd_data = bus_rd_data;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            r_rd_buf    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_bus_hit) begin
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        bus_req_    <= 1'b0;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        bus_as_ <= 1'b0;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe is a single-cycle pulse even when the slave inserts wait states.
                    bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        bus_req_ <= 1'b1;
                        r_rd_buf <= bus_rd_data;
                        r_state  <= stall ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (flush || !stall) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_if.sv
module tb_bus_if;

    logic        clk = 1'b0;
    logic        reset_;
    logic        stall, flush, busy;
    logic [29:0] addr;
    logic        as_, rw;
    logic [31:0] wr_data, rd_data, spm_rd_data;
    logic [11:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [31:0] spm_wr_data, bus_rd_data;
    logic        bus_rdy_, bus_grnt_, bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_, bus_rw;
    logic [31:0] bus_wr_data;

    always #5 clk = ~clk;

    bus_if dut (
        .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
        .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an open bus transaction (granted or not),
    // a held result under stall, the strobe pulse, and the last latched request.
    bit          m_open, m_granted, m_holding, m_as_pulse;
    logic [29:0] m_addr;
    logic        m_rw;
    logic [31:0] m_wdat, m_buf;

    always @(negedge clk) begin : compare
        bit          idle, region_spm, hit_spm, hit_bus, exp_busy, rd_valid;
        logic [31:0] exp_rd;
        if (!reset_) begin
            m_open = 0; m_granted = 0; m_holding = 0; m_as_pulse = 0;
            m_addr = '0; m_rw = 1'b1; m_wdat = '0; m_buf = '0;
        end
        idle       = !m_open && !m_holding;
        region_spm = (addr[29:27] == 3'b001);
        hit_spm    = idle && !as_ && !flush && region_spm;
        hit_bus    = idle && !as_ && !flush && !region_spm;
        if (idle)                exp_busy = hit_bus;
        else if (m_holding)      exp_busy = 1'b0;
        else if (!m_granted)     exp_busy = 1'b1;
        else                     exp_busy = bus_rdy_;
        rd_valid = 1'b1;
        exp_rd   = m_buf;
        if (hit_spm)                               exp_rd = spm_rd_data;
        else if (m_open && m_granted && !bus_rdy_) exp_rd = bus_rd_data;
        else if (m_open)                           rd_valid = 1'b0;

        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (rd_valid) chk("rd_data", rd_data, exp_rd);
        chk("spm_as_", {31'd0, spm_as_}, {31'd0, !hit_spm});
        chk("spm_addr", {20'd0, spm_addr}, {20'd0, addr[11:0]});
        chk("spm_rw", {31'd0, spm_rw}, {31'd0, rw});
        chk("spm_wr_data", spm_wr_data, wr_data);
        chk("bus_req_", {31'd0, bus_req_}, {31'd0, !m_open});
        chk("bus_as_", {31'd0, bus_as_}, {31'd0, !m_as_pulse});
        chk("bus_addr", {2'd0, bus_addr}, {2'd0, m_addr});
        chk("bus_rw", {31'd0, bus_rw}, {31'd0, m_rw});
        chk("bus_wr_data", bus_wr_data, m_wdat);

        if (reset_) begin
            if (hit_bus) begin
                m_open = 1; m_granted = 0;
                m_addr = addr; m_rw = rw; m_wdat = wr_data;
            end else if (m_open && !m_granted) begin
                if (!bus_grnt_) begin
                    m_granted = 1; m_as_pulse = 1;
                end
            end else if (m_open) begin
                m_as_pulse = 0;
                if (!bus_rdy_) begin
                    m_buf = bus_rd_data; m_open = 0; m_holding = stall;
                end
            end else if (m_holding && (flush || !stall)) begin
                m_holding = 0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic quiet();
        as_ = 1'b1; flush = 1'b0; stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    endtask

    initial begin
        int busy_n, asl_n;
        logic [2:0] sel;
        reset_ = 1'b0;
        quiet();
        addr = '0; rw = 1'b1; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
        repeat (2) nxt();
        mid();
        chk("rst_bus_req_", {31'd0, bus_req_}, 32'd1);
        chk("rst_bus_as_", {31'd0, bus_as_}, 32'd1);
        chk("rst_bus_rw", {31'd0, bus_rw}, 32'd1);
        chk("rst_bus_addr", {2'd0, bus_addr}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        nxt(); reset_ = 1'b1;

        // SPM read
        nxt(); addr = 30'h0800_0004; as_ = 1'b0; rw = 1'b1; spm_rd_data = 32'h0000_1111;
        mid();
        chk("spm_rd_as_", {31'd0, spm_as_}, 32'd0);
        chk("spm_rd_addr", {20'd0, spm_addr}, 32'h004);
        chk("spm_rd_busy", {31'd0, busy}, 32'd0);
        chk("spm_rd_req_", {31'd0, bus_req_}, 32'd1);
        chk("spm_rd_data", rd_data, 32'h0000_1111);

        // Bus read, immediate grant and ready
        nxt(); addr = 30'h0000_0010; as_ = 1'b0; rw = 1'b1;
        mid(); chk("brd_c0_busy", {31'd0, busy}, 32'd1);
        nxt(); as_ = 1'b1; bus_grnt_ = 1'b0;
        mid();
        chk("brd_c1_req_", {31'd0, bus_req_}, 32'd0);
        chk("brd_c1_busy", {31'd0, busy}, 32'd1);
        chk("brd_c1_as_", {31'd0, bus_as_}, 32'd1);
        nxt(); bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        mid();
        chk("brd_c2_as_", {31'd0, bus_as_}, 32'd0);
        chk("brd_c2_req_", {31'd0, bus_req_}, 32'd0);
        chk("brd_c2_busy", {31'd0, busy}, 32'd0);
        chk("brd_c2_rd", rd_data, 32'hDEAD_BEEF);
        nxt(); bus_rdy_ = 1'b1; bus_rd_data = 32'd0;
        mid();
        chk("brd_c3_req_", {31'd0, bus_req_}, 32'd1);
        chk("brd_c3_rdbuf", rd_data, 32'hDEAD_BEEF);

        // Bus write, grant delayed 4 cycles; stage inputs wiggle meanwhile
        busy_n = 0; asl_n = 0;
        nxt(); addr = 30'h0000_0020; rw = 1'b0; wr_data = 32'h1234_5678; as_ = 1'b0;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            if (cyc > 0) begin
                nxt();
                as_       = (cyc >= 7);
                rw        = 1'b1;
                wr_data   = 32'hFFFF_0000;
                addr      = 30'h0000_0030;
                bus_grnt_ = (cyc != 5);
                bus_rdy_  = (cyc != 7);
            end
            mid();
            busy_n += int'(busy);
            asl_n  += int'(!bus_as_);
            if (cyc >= 1 && cyc <= 7) begin
                chk("bwr_rw", {31'd0, bus_rw}, 32'd0);
                chk("bwr_wdat", bus_wr_data, 32'h1234_5678);
                chk("bwr_addr", {2'd0, bus_addr}, 32'h20);
            end
        end
        chk("bwr_busy_cycles", busy_n, 32'd7);
        chk("bwr_as_pulses", asl_n, 32'd1);
        rw = 1'b1; quiet();

        // Stall on completion holds data in WAIT
        nxt(); addr = 30'h0000_0040; as_ = 1'b0;
        nxt(); as_ = 1'b1; bus_grnt_ = 1'b0;
        nxt(); bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_A5A5; stall = 1'b1;
        mid();
        chk("stl_rd", rd_data, 32'hA5A5_A5A5);
        chk("stl_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            nxt(); bus_rdy_ = 1'b1; bus_rd_data = $urandom; as_ = 1'b0; addr = 30'h0000_0050;
            mid();
            chk("stl_hold_rd", rd_data, 32'hA5A5_A5A5);
            chk("stl_hold_busy", {31'd0, busy}, 32'd0);
            chk("stl_hold_req_", {31'd0, bus_req_}, 32'd1);
        end
        nxt(); stall = 1'b0; as_ = 1'b1;
        mid(); chk("stl_release_rd", rd_data, 32'hA5A5_A5A5);
        nxt(); addr = 30'h0800_0008; as_ = 1'b0; spm_rd_data = 32'h2222;
        mid();
        chk("stl_idle_spm_as_", {31'd0, spm_as_}, 32'd0);
        chk("stl_idle_busy", {31'd0, busy}, 32'd0);
        nxt(); quiet();

        // Flush masks a new bus request
        nxt(); as_ = 1'b0; flush = 1'b1; addr = 30'h0000_0060;
        mid(); chk("fl_new_busy", {31'd0, busy}, 32'd0);
        nxt(); as_ = 1'b1; flush = 1'b0;
        mid(); chk("fl_new_req_", {31'd0, bus_req_}, 32'd1);

        // Flush during ACCESS does not abort
        nxt(); addr = 30'h0000_0070; as_ = 1'b0;
        nxt(); as_ = 1'b1; bus_grnt_ = 1'b0;
        nxt(); bus_grnt_ = 1'b1; flush = 1'b1;
        mid(); chk("fl_acc_busy", {31'd0, busy}, 32'd1);
        nxt(); bus_rdy_ = 1'b0; bus_rd_data = 32'h0BAD_F00D;
        mid();
        chk("fl_acc_done_busy", {31'd0, busy}, 32'd0);
        chk("fl_acc_rd", rd_data, 32'h0BAD_F00D);
        nxt(); bus_rdy_ = 1'b1; flush = 1'b0;
        mid();
        chk("fl_acc_req_", {31'd0, bus_req_}, 32'd1);
        chk("fl_acc_rdbuf", rd_data, 32'h0BAD_F00D);

        // Asynchronous reset while in ACCESS
        nxt(); addr = 30'h0000_0080; as_ = 1'b0;
        nxt(); as_ = 1'b1; bus_grnt_ = 1'b0;
        nxt(); bus_grnt_ = 1'b1;
        #2 reset_ = 1'b0;
        #1;
        chk("arst_req_", {31'd0, bus_req_}, 32'd1);
        chk("arst_as_", {31'd0, bus_as_}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        nxt();
        nxt(); reset_ = 1'b1; addr = 30'h0800_000C; as_ = 1'b0; spm_rd_data = 32'h3333;
        mid();
        chk("arst_spm_as_", {31'd0, spm_as_}, 32'd0);
        chk("arst_spm_busy", {31'd0, busy}, 32'd0);
        chk("arst_spm_rd", rd_data, 32'h3333);
        chk("arst_spm_addr", {20'd0, spm_addr}, 32'h00C);

        // Randomized traffic checked by the reference each cycle
        for (int n = 0; n < 3000; n++) begin
            nxt();
            sel         = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom);
            addr        = {sel, 27'($urandom)};
            as_         = ($urandom_range(0, 2) == 0);
            rw          = 1'($urandom);
            wr_data     = $urandom;
            flush       = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 2) == 0);
            bus_grnt_   = 1'($urandom);
            bus_rdy_    = 1'($urandom);
            spm_rd_data = $urandom;
            bus_rd_data = $urandom;
        end

        nxt(); quiet();
        mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
